// File: rtl/simon_playback_if.sv
// simon_playback_if: playback bus between the game controller/pattern memory (master) and the engine (slave).
// Rev 1.0
`default_nettype none

interface simon_playback_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first;
  logic [ADDR_W-1:0] last;
  logic              fast;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] leds;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, first, last, fast, r_data,
    input  r_addr, leds, busy, done
  );

  modport slave (
    input  start, abort, first, last, fast, r_data,
    output r_addr, leds, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/simon_playback.sv
// simon_playback: walks pattern memory from first to last (inclusive, wrapping) showing each entry then a blank gap.
// Rev 1.0
`default_nettype none

module simon_playback #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 4,
  parameter int ON_SLOW = 8,
  parameter int ON_FAST = 4,
  parameter int GAP     = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  simon_playback_if.slave  bus
);

  localparam int TMAX = (ON_SLOW > ON_FAST) ? ((ON_SLOW > GAP) ? ON_SLOW : GAP)
                                            : ((ON_FAST > GAP) ? ON_FAST : GAP);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] c_ON_SLOW_M1 = TW'(ON_SLOW - 1);
  localparam logic [TW-1:0] c_ON_FAST_M1 = TW'(ON_FAST - 1);
  localparam logic [TW-1:0] c_GAP_M1     = TW'(GAP - 1);

  generate
    if (ON_SLOW < 1 || ON_FAST < 1 || GAP < 1) begin : g_bad_timing
      $error("simon_playback: ON_SLOW, ON_FAST and GAP must all be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_timer;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic              r_fast;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] w_leds;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_addr  <= '0;
      r_last  <= '0;
      r_fast  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_timer <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_state <= S_SHOW;
              r_addr  <= bus.first;
              r_last  <= bus.last;
              r_fast  <= bus.fast;
              r_timer <= bus.fast ? c_ON_FAST_M1 : c_ON_SLOW_M1;
              r_busy  <= 1'b1;
            end
          end
          S_SHOW: begin
            if (r_timer == '0) begin
              r_state <= S_GAP;
              r_timer <= c_GAP_M1;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          S_GAP: begin
            if (r_timer != '0) begin
              r_timer <= r_timer - 1'b1;
            end else if (r_addr == r_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // Address wraps naturally at the top of memory.
              r_addr  <= r_addr + 1'b1;
              r_state <= S_SHOW;
              r_timer <= r_fast ? c_ON_FAST_M1 : c_ON_SLOW_M1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Memory read is combinational from r_addr, so the LEDs follow r_data in the same cycle.
  assign w_leds = (r_state == S_SHOW) ? bus.r_data : '0;

  assign bus.r_addr = r_addr;
  assign bus.leds   = w_leds;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_simon_playback.sv
// tb_simon_playback: directed playback scenarios checked every cycle against a schedule-based reference model.
`default_nettype none

module tb_simon_playback;

  logic clk;
  logic rst_n;
  logic [3:0] mem [64];

  simon_playback_if #(.ADDR_W(6), .DATA_W(4)) bus ();

  simon_playback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.r_data = mem[bus.r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cur    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: playback described as a schedule indexed by cycle number since start.
  bit         m_active;
  int         m_k, m_N, m_T, m_on, m_first;
  logic [5:0] m_addr;

  always @(posedge clk or negedge rst_n) begin : model
    bit idle_now;
    if (!rst_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_addr   = '0;
    end else begin
      idle_now = !m_active || (m_k > m_N * m_T);
      if (bus.abort) begin
        m_active = 1'b0;
      end else if (idle_now && bus.start) begin
        m_first  = int'(bus.first);
        m_N      = ((int'(bus.last) - int'(bus.first) + 64) % 64) + 1;
        m_on     = bus.fast ? 4 : 8;
        m_T      = m_on + 2;
        m_k      = 1;
        m_active = 1'b1;
      end else if (m_active) begin
        m_k++;
        if (m_k > m_N * m_T + 1) m_active = 1'b0;
      end
      if (m_active && m_k <= m_N * m_T)
        m_addr = 6'((m_first + (m_k - 1) / m_T) % 64);
    end
  end

  always @(negedge clk) begin : compare
    bit         e_busy, e_done;
    logic [3:0] e_leds;
    e_busy = m_active && (m_k <= m_N * m_T);
    e_done = m_active && (m_k == m_N * m_T + 1);
    e_leds = (e_busy && ((m_k - 1) % m_T) < m_on) ? mem[m_addr] : 4'h0;
    chk("r_addr", 32'(bus.r_addr), 32'(m_addr));
    chk("leds",   32'(bus.leds),   32'(e_leds));
    chk("busy",   32'(bus.busy),   32'(e_busy));
    chk("done",   32'(bus.done),   32'(e_done));
  end

  task automatic to_cycle(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic pulse_start(input logic [5:0] f, input logic [5:0] l, input logic fa);
    @(negedge clk); #1;
    bus.first = f; bus.last = l; bus.fast = fa; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    cur = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.first = '0; bus.last = '0; bus.fast = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 4'($urandom_range(0, 15));

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      bus.start = 1'($urandom); bus.abort = 1'($urandom); bus.fast = 1'($urandom);
      bus.first = 6'($urandom); bus.last = 6'($urandom);
    end
    #1;
    chk("rst_addr", 32'(bus.r_addr), 32'h0);
    chk("rst_leds", 32'(bus.leds), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.first = '0; bus.last = '0; bus.fast = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single entry.
    mem[5] = 4'b0100;
    pulse_start(6'd5, 6'd5, 1'b0);
    chk("single_leds_c1", 32'(bus.leds), 32'h4);
    chk("single_busy_c1", 32'(bus.busy), 32'h1);
    to_cycle(9);
    chk("single_leds_c9", 32'(bus.leds), 32'h0);
    to_cycle(10);
    chk("single_busy_c10", 32'(bus.busy), 32'h1);
    to_cycle(11);
    chk("single_done_c11", 32'(bus.done), 32'h1);
    chk("single_busy_c11", 32'(bus.busy), 32'h0);
    to_cycle(12);
    chk("single_done_c12", 32'(bus.done), 32'h0);
    to_cycle(14);

    // Wrap-around, fast.
    mem[62] = 4'd1; mem[63] = 4'd2; mem[0] = 4'd4; mem[1] = 4'd8;
    pulse_start(6'd62, 6'd1, 1'b1);
    chk("wrap_addr_c1", 32'(bus.r_addr), 32'd62);
    to_cycle(13);
    chk("wrap_addr_c13", 32'(bus.r_addr), 32'd0);
    chk("wrap_leds_c13", 32'(bus.leds), 32'h4);
    to_cycle(17);
    chk("wrap_leds_c17", 32'(bus.leds), 32'h0);
    to_cycle(19);
    chk("wrap_leds_c19", 32'(bus.leds), 32'h8);
    to_cycle(25);
    chk("wrap_done_c25", 32'(bus.done), 32'h1);
    to_cycle(27);

    // Full memory.
    pulse_start(6'd10, 6'd9, 1'b0);
    to_cycle(541);
    chk("full_addr_c541", 32'(bus.r_addr), 32'd0);
    to_cycle(640);
    chk("full_busy_c640", 32'(bus.busy), 32'h1);
    to_cycle(641);
    chk("full_done_c641", 32'(bus.done), 32'h1);
    chk("full_addr_c641", 32'(bus.r_addr), 32'd9);
    to_cycle(643);

    // Abort mid-playback.
    pulse_start(6'd20, 6'd22, 1'b0);
    to_cycle(12);
    bus.abort = 1'b1;
    to_cycle(13);
    bus.abort = 1'b0;
    chk("abort_busy_c13", 32'(bus.busy), 32'h0);
    chk("abort_leds_c13", 32'(bus.leds), 32'h0);
    to_cycle(45);

    // Start while busy is ignored.
    pulse_start(6'd30, 6'd31, 1'b1);
    to_cycle(5);
    bus.start = 1'b1; bus.first = 6'd0; bus.last = 6'd40; bus.fast = 1'b0;
    to_cycle(6);
    bus.start = 1'b0;
    to_cycle(7);
    chk("ign_addr_c7", 32'(bus.r_addr), 32'd31);
    to_cycle(13);
    chk("ign_done_c13", 32'(bus.done), 32'h1);
    to_cycle(15);

    // Start and abort together in IDLE.
    bus.start = 1'b1; bus.abort = 1'b1; bus.first = 6'd3; bus.last = 6'd3;
    to_cycle(16);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_busy", 32'(bus.busy), 32'h0);
    to_cycle(18);
    chk("sa_busy_later", 32'(bus.busy), 32'h0);

    // Reset during GAP of entry 2.
    pulse_start(6'd40, 6'd45, 1'b0);
    to_cycle(29);
    chk("rstm_busy_before", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstm_addr", 32'(bus.r_addr), 32'h0);
    chk("rstm_leds", 32'(bus.leds), 32'h0);
    chk("rstm_busy", 32'(bus.busy), 32'h0);
    chk("rstm_done", 32'(bus.done), 32'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    mem[0] = 4'b1010;
    pulse_start(6'd0, 6'd0, 1'b0);
    chk("post_leds_c1", 32'(bus.leds), 32'ha);
    to_cycle(11);
    chk("post_done_c11", 32'(bus.done), 32'h1);
    to_cycle(13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
